// File: rtl/line_matrix_programmer_if.sv
// Control and matrix-line bundle for the line-matrix programmer.
// The master drives the request side; the slave drives the matrix lines.
interface line_matrix_programmer_if #(
  parameter int N_OUT = 9,
  parameter int SEL_W = 4
);
  logic                   start;
  logic [N_OUT*SEL_W-1:0] route_map;
  logic [N_OUT-1:0]       route_en;
  logic                   busy;
  logic                   done;
  logic                   err_sel;
  logic                   lm_clk;
  logic                   lm_rstn;
  logic [SEL_W-1:0]       lm_input_select;
  logic [SEL_W-1:0]       lm_output_select;

  modport master (
    output start, route_map, route_en,
    input  busy, done, err_sel,
    input  lm_clk, lm_rstn,
    input  lm_input_select, lm_output_select
  );

  modport slave (
    input  start, route_map, route_en,
    output busy, done, err_sel,
    output lm_clk, lm_rstn,
    output lm_input_select, lm_output_select
  );
endinterface

// File: rtl/line_matrix_programmer.sv
// Line-matrix programmer: clears the matrix, then strobes
// one route per enabled table entry into it.
module line_matrix_programmer #(
  parameter int N_OUT      = 9,
  parameter int N_IN       = 8,
  parameter int SEL_W      = 4,
  parameter int RST_CYCLES = 4,
  parameter int HALF_PER   = 2
) (
  input logic clk,
  input logic rstn,
  line_matrix_programmer_if.slave bus
);

  localparam int JW = $clog2(N_OUT) + 1;
  localparam int CW = $clog2(RST_CYCLES + HALF_PER) + 1;

  typedef enum logic [2:0] {
    IDLE, CLEAR, EVAL, SETUP, STROBE, DONE
  } state_t;

  state_t                 state;
  logic [N_OUT*SEL_W-1:0] map_q;
  logic [N_OUT-1:0]       en_q;
  logic [JW-1:0]          j;
  logic [CW-1:0]          cnt;
  logic                   busy;
  logic                   done;
  logic                   err_sel;
  logic                   lm_clk;
  logic                   lm_rstn;
  logic [SEL_W-1:0]       in_sel;
  logic [SEL_W-1:0]       out_sel;
  logic                   legal;
  logic                   last;

  // Snapshot is shifted down each EVAL, so entry j always sits at bit 0.
  assign legal = {1'b0, map_q[SEL_W-1:0]} < (SEL_W+1)'(N_IN);
  assign last  = (j == JW'(N_OUT - 1));

  assign bus.busy             = busy;
  assign bus.done             = done;
  assign bus.err_sel          = err_sel;
  assign bus.lm_clk           = lm_clk;
  assign bus.lm_rstn          = lm_rstn;
  assign bus.lm_input_select  = in_sel;
  assign bus.lm_output_select = out_sel;

  // Sequencer: clear, then evaluate/setup/strobe per entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      map_q   <= '0;
      en_q    <= '0;
      j       <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err_sel <= 1'b0;
      lm_clk  <= 1'b0;
      lm_rstn <= 1'b0;
      in_sel  <= '0;
      out_sel <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          lm_clk <= 1'b0;
          if (bus.start) begin
            map_q   <= bus.route_map;
            en_q    <= bus.route_en;
            err_sel <= 1'b0;
            j       <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            lm_rstn <= 1'b0;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          if (cnt == CW'(RST_CYCLES - 1)) begin
            cnt     <= '0;
            lm_rstn <= 1'b1;
            state   <= EVAL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        EVAL: begin
          en_q  <= en_q >> 1;
          map_q <= map_q >> SEL_W;
          if (en_q[0] && !legal) begin
            err_sel <= 1'b1;
          end
          if (en_q[0] && legal) begin
            in_sel  <= map_q[SEL_W-1:0];
            out_sel <= SEL_W'(j);
            cnt     <= '0;
            state   <= SETUP;
          end else if (last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            j <= j + 1'b1;
          end
        end
        SETUP: begin
          if (cnt == CW'(HALF_PER - 1)) begin
            cnt    <= '0;
            lm_clk <= 1'b1;
            state  <= STROBE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STROBE: begin
          if (cnt == CW'(HALF_PER - 1)) begin
            cnt    <= '0;
            lm_clk <= 1'b0;
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              j     <= j + 1'b1;
              state <= EVAL;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
